// File: rtl/xbar_pkg.sv
// Shared widths and command encodings for the crossbar memory slave.
package xbar_pkg;
  localparam int   DATA_W    = 32;
  localparam int   ADDR_W    = 32;
  localparam int   WORD_LSB  = 2;
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;
endpackage

// File: rtl/xbar_mem_slave_ram.sv
// 1R1W synchronous word array with a registered read port.
// The read register holds its value whenever re is low. The array is not reset.
module xbar_mem_slave_ram
  import xbar_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // write port: commit on the cycle we is high
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // read port next value: new word on re, otherwise hold
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[ridx];
  end

  // read data register
  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/xbar_mem_slave.sv
// Memory-backed responder behind one crossbar slave port.
// Optional wait states are enabled by defining XBAR_SLAVE_STALL_EN; without it
// every request is acked in the cycle it is presented.
module xbar_mem_slave
  import xbar_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              slave_req,
  input  logic [ADDR_W-1:0] slave_addr,
  input  logic              slave_cmd,
  input  logic [DATA_W-1:0] slave_wdata,
  output logic              slave_ack,
  output logic [DATA_W-1:0] slave_rdata
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0]  idx;
  logic              ack;
  logic              wr_en, rd_en;
  logic [DATA_W-1:0] ram_rdata;
  logic              rd_valid_q, rd_valid_d;

  // Word index; high bits (including the crossbar select bit) and byte bits alias.
  assign idx = slave_addr[WORD_LSB +: IDX_W];

  logic unused_bits;
  assign unused_bits = ^{WAIT_CYCLES[0], slave_addr[WORD_LSB-1:0],
                         slave_addr[ADDR_W-1:WORD_LSB+IDX_W]};

`ifdef XBAR_SLAVE_STALL_EN
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  logic [3:0] cnt_q, cnt_d;

  // ack once req has been held WAIT_CYCLES cycles; counter restarts on ack or req drop
  always_comb begin
    ack   = slave_req & rst_n & (cnt_q == WAIT_LIM);
    cnt_d = '0;
    if (ack)            cnt_d = '0;
    else if (slave_req) cnt_d = cnt_q + 4'd1;
  end

  // wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // zero wait states: ack any request outside reset
  always_comb begin
    ack = slave_req & rst_n;
  end
`endif

  assign slave_ack = ack;
  assign wr_en     = ack & (slave_cmd == CMD_WRITE);
  assign rd_en     = ack & (slave_cmd == CMD_READ);

  xbar_mem_slave_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .widx  (idx),
    .wdata (slave_wdata),
    .re    (rd_en),
    .ridx  (idx),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; mask it to zero until the first read
  // after reset so slave_rdata reads back 0 out of reset.
  always_comb begin
    rd_valid_d = rd_valid_q | rd_en;
  end

  // read-valid flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_valid_q <= 1'b0;
    else        rd_valid_q <= rd_valid_d;
  end

  assign slave_rdata = rd_valid_q ? ram_rdata : '0;

endmodule

// File: tb/tb_xbar_mem_slave.sv
// Directed bench for xbar_mem_slave (DEPTH=256, WAIT_CYCLES=2).
// Expected wait states follow XBAR_SLAVE_STALL_EN: 2 when defined, 0 otherwise.
module tb_xbar_mem_slave;
  import xbar_pkg::*;

`ifdef XBAR_SLAVE_STALL_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        slave_req;
  logic [31:0] slave_addr;
  logic        slave_cmd;
  logic [31:0] slave_wdata;
  logic        slave_ack;
  logic [31:0] slave_rdata;

  int checks   = 0;
  int failures = 0;
  int ack_cnt  = 0;

  xbar_mem_slave #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .slave_req   (slave_req),
    .slave_addr  (slave_addr),
    .slave_cmd   (slave_cmd),
    .slave_wdata (slave_wdata),
    .slave_ack   (slave_ack),
    .slave_rdata (slave_rdata)
  );

  always #5 clk = ~clk;

  // count accepted transfers
  always @(posedge clk) if (slave_ack === 1'b1) ack_cnt++;

  // Present one request and hold it until acked. Returns the number of
  // non-ack cycles seen before the ack; exits 1 ns after the ack edge with req low.
  task automatic xfer(input logic cmd, input logic [31:0] addr,
                      input logic [31:0] wd, output int wcyc);
    slave_req = 1'b1; slave_cmd = cmd; slave_addr = addr; slave_wdata = wd;
    wcyc = 0;
    #2;
    while (slave_ack !== 1'b1 && wcyc < TMO) begin
      @(posedge clk); #3;
      wcyc++;
    end
    checks++;
    if (slave_ack !== 1'b1) begin
      failures++;
      $display("FAIL xfer_timeout: addr %h no ack after %0d cycles", addr, wcyc);
    end
    @(posedge clk); #1;
    slave_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; slave_req = 1'b1; slave_cmd = CMD_READ;
    slave_addr = 32'h10; slave_wdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      checks++;
      if (slave_ack !== 1'b0) begin
        failures++; $display("FAIL reset_ack: cyc %0d got %b expected 0", i, slave_ack);
      end
      checks++;
      if (slave_rdata !== 32'h0) begin
        failures++; $display("FAIL reset_rdata: cyc %0d got %h expected 0", i, slave_rdata);
      end
    end
    @(posedge clk); #1;
    slave_req = 1'b0; rst_n = 1'b1;
    #2;
    checks++;
    if (slave_ack !== 1'b0) begin
      failures++; $display("FAIL release_idle_ack: got %b expected 0", slave_ack);
    end
    checks++;
    if (slave_rdata !== 32'h0) begin
      failures++; $display("FAIL release_rdata: got %h expected 0", slave_rdata);
    end
  endtask

  task automatic test_basic;
    int w; int a0;
    a0 = ack_cnt;
    xfer(CMD_WRITE, 32'h0000_0010, 32'hDEAD_BEEF, w);
    checks++;
    if (w != EXP_WAIT) begin
      failures++; $display("FAIL basic_wr_wait: got %0d expected %0d", w, EXP_WAIT);
    end
    xfer(CMD_READ, 32'h0000_0010, 32'h0, w);
    checks++;
    if (w != EXP_WAIT) begin
      failures++; $display("FAIL basic_rd_wait: got %0d expected %0d", w, EXP_WAIT);
    end
    checks++;
    if (slave_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL basic_rdata: got %h expected deadbeef", slave_rdata);
    end
    checks++;
    if (ack_cnt - a0 != 2) begin
      failures++; $display("FAIL basic_ack_count: got %0d expected 2", ack_cnt - a0);
    end
  endtask

  task automatic test_stall;
    int w; int a0;
    a0 = ack_cnt;
    xfer(CMD_WRITE, 32'h0000_0030, 32'h1357_9BDF, w);
    checks++;
    if (w != EXP_WAIT) begin
      failures++; $display("FAIL stall_wait: got %0d expected %0d", w, EXP_WAIT);
    end
    checks++;
    if (ack_cnt - a0 != 1) begin
      failures++; $display("FAIL stall_one_ack: got %0d expected 1", ack_cnt - a0);
    end
    // idle cycle between requests: counter restarts from zero
    @(posedge clk); #1;
    xfer(CMD_READ, 32'h0000_0030, 32'h0, w);
    checks++;
    if (w != EXP_WAIT) begin
      failures++; $display("FAIL stall_restart_wait: got %0d expected %0d", w, EXP_WAIT);
    end
    checks++;
    if (slave_rdata !== 32'h1357_9BDF) begin
      failures++; $display("FAIL stall_rdata: got %h expected 13579bdf", slave_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int w;
    xfer(CMD_WRITE, 32'h0000_0014, 32'hA5A5_5A5A, w);
    xfer(CMD_READ,  32'h0000_0014, 32'h0, w);
    checks++;
    if (slave_rdata !== 32'hA5A5_5A5A) begin
      failures++; $display("FAIL b2b_rdata: got %h expected a5a55a5a", slave_rdata);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (slave_rdata !== 32'hA5A5_5A5A) begin
      failures++; $display("FAIL idle_hold: got %h expected a5a55a5a", slave_rdata);
    end
    xfer(CMD_WRITE, 32'h0000_0018, 32'h0BAD_F00D, w);
    checks++;
    if (slave_rdata !== 32'hA5A5_5A5A) begin
      failures++; $display("FAIL write_hold: got %h expected a5a55a5a", slave_rdata);
    end
  endtask

  task automatic test_alias;
    int w;
    xfer(CMD_WRITE, 32'h0000_0400, 32'h1111_1111, w);
    xfer(CMD_READ, 32'h0000_0000, 32'h0, w);
    checks++;
    if (slave_rdata !== 32'h1111_1111) begin
      failures++; $display("FAIL alias_0000: got %h expected 11111111", slave_rdata);
    end
    xfer(CMD_WRITE, 32'h0000_0014, 32'h2222_2222, w);
    xfer(CMD_READ, 32'h8000_0000, 32'h0, w);
    checks++;
    if (slave_rdata !== 32'h1111_1111) begin
      failures++; $display("FAIL alias_8000: got %h expected 11111111", slave_rdata);
    end
    xfer(CMD_READ, 32'h0000_0017, 32'h0, w);
    checks++;
    if (slave_rdata !== 32'h2222_2222) begin
      failures++; $display("FAIL alias_bytebits: got %h expected 22222222", slave_rdata);
    end
  endtask

  task automatic test_reset_midreq;
    int w;
    xfer(CMD_WRITE, 32'h0000_0020, 32'hCAFE_F00D, w);
    slave_req = 1'b1; slave_cmd = CMD_READ; slave_addr = 32'h0000_0020;
    if (EXP_WAIT > 0) begin
      #2;
      checks++;
      if (slave_ack !== 1'b0) begin
        failures++; $display("FAIL midreq_pending_ack: got %b expected 0", slave_ack);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (slave_ack !== 1'b0) begin
      failures++; $display("FAIL midreq_reset_ack: got %b expected 0", slave_ack);
    end
    checks++;
    if (slave_rdata !== 32'h0) begin
      failures++; $display("FAIL midreq_reset_rdata: got %h expected 0", slave_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    w = 0;
    #2;
    while (slave_ack !== 1'b1 && w < TMO) begin
      @(posedge clk); #3;
      w++;
    end
    checks++;
    if (w != EXP_WAIT) begin
      failures++; $display("FAIL midreq_post_wait: got %0d expected %0d", w, EXP_WAIT);
    end
    @(posedge clk); #1;
    slave_req = 1'b0;
    checks++;
    if (slave_rdata !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL midreq_rdata: got %h expected cafef00d", slave_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_alias();
    test_reset_midreq();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
